// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: op-mode encoding,
// parameter limits and the chunk-width computation.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned WIDTH_MIN  = 2;
    localparam int unsigned WIDTH_MAX  = 64;
    localparam int unsigned STAGES_MIN = 1;

    // Bits handled per stage; the top chunk absorbs the remainder
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: ripple add of a W-bit chunk with registered sum,
// carry and valid. Holds its state when i_en is low.
module pipe_adder_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_valid
);

    logic [W:0]   w_c;
    logic [W-1:0] w_s;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_valid;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    // Capture chunk result and carry when the pipeline advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_sum   <= w_s;
            r_cout  <= w_c[W];
            r_valid <= i_valid;
        end
    end

    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready handshake. The operand is cut
// into chunks, one per stage; carries ripple between stages one cycle
// apart while upper operand chunks are skewed forward and finished lower
// sum chunks are delayed so the whole result leaves in one cycle.
module pipelined_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int unsigned CH  = chunk_width(WIDTH, STAGES);
    localparam int unsigned MSB = WIDTH - 1;

    logic             w_en;
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic             w_sub   [STAGES];
    logic             w_v     [STAGES+1];
    logic             w_c     [STAGES+1];
    logic             w_am    [STAGES+1];
    logic             w_bm    [STAGES+1];
    logic [WIDTH-1:0] w_lo    [1:STAGES];
    logic [WIDTH-1:0] w_place [STAGES];

    // Whole pipeline freezes while a result waits for the consumer
    assign w_en     = !(w_v[STAGES] && !out_ready);
    assign in_ready = w_en;

    assign w_a[0]   = A;
    assign w_b[0]   = B;
    assign w_sub[0] = (op_sub == OP_SUB);
    assign w_v[0]   = in_valid;
    assign w_c[0]   = (op_sub == OP_SUB) ? ~Cin : Cin;
    assign w_am[0]  = A[MSB];
    assign w_bm[0]  = B[MSB] ^ (op_sub == OP_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO = k * CH;

        if (LO < WIDTH) begin : g_add
            localparam int unsigned HI = (LO + CH < WIDTH) ? LO + CH - 1 : WIDTH - 1;
            localparam int unsigned W  = HI - LO + 1;

            logic [W-1:0] w_s;
            logic [W-1:0] w_bc;

            assign w_bc = w_b[k][HI:LO] ^ {W{w_sub[k]}};

            pipe_adder_stage #(.W(W)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_en),
                .i_valid (w_v[k]),
                .i_a     (w_a[k][HI:LO]),
                .i_b     (w_bc),
                .i_cin   (w_c[k]),
                .o_sum   (w_s),
                .o_cout  (w_c[k+1]),
                .o_valid (w_v[k+1])
            );

            assign w_place[k] = WIDTH'(w_s) << LO;
        end else begin : g_pass
            // Ceiling split can leave trailing stages with no bits; they
            // still delay valid and carry so latency stays STAGES.
            logic r_v;
            logic r_c;

            // Delay valid and carry through an empty stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                end else if (w_en) begin
                    r_v <= w_v[k];
                    r_c <= w_c[k];
                end
            end

            assign w_v[k+1]   = r_v;
            assign w_c[k+1]   = r_c;
            assign w_place[k] = '0;
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_sub;

            // Carry unconsumed operand chunks and mode to the next stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sub <= 1'b0;
                end else if (w_en) begin
                    r_a   <= w_a[k];
                    r_b   <= w_b[k];
                    r_sub <= w_sub[k];
                end
            end

            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_sub[k+1] = r_sub;
        end

        logic r_am;
        logic r_bm;

        // Operand sign bits ride along for the overflow flag at the output
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_am <= 1'b0;
                r_bm <= 1'b0;
            end else if (w_en) begin
                r_am <= w_am[k];
                r_bm <= w_bm[k];
            end
        end

        assign w_am[k+1] = r_am;
        assign w_bm[k+1] = r_bm;

        if (k == 0) begin : g_lo0
            assign w_lo[1] = '0;
        end else begin : g_lo
            logic [WIDTH-1:0] r_lo;

            // Collect finished lower chunks, aligned with the current stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lo <= '0;
                end else if (w_en) begin
                    r_lo <= w_lo[k] | w_place[k-1];
                end
            end

            assign w_lo[k+1] = r_lo;
        end
    end

    assign out_valid = w_v[STAGES];
    assign Cout      = w_c[STAGES];
    assign Sum       = w_lo[STAGES] | w_place[STAGES-1];
    assign ovf       = (w_am[STAGES] == w_bm[STAGES]) && (Sum[MSB] != w_am[STAGES]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=11, STAGES=3).
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] A;
    logic [10:0] B;
    logic        Cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] Sum;
    logic        Cout;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_adder #(.WIDTH(11), .STAGES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, Cout, Sum}
    function automatic logic [12:0] model(input logic [10:0] a, input logic [10:0] b,
                                          input logic cin, input logic sub);
        logic [10:0] bb;
        logic        ci;
        logic [11:0] t;
        logic        v;
        bb = sub ? ~b : b;
        ci = sub ? ~cin : cin;
        t  = {1'b0, a} + {1'b0, bb} + {11'd0, ci};
        v  = (a[10] == bb[10]) && (t[10] != a[10]);
        return {v, t};
    endfunction

    // Called at a negedge: drives one op and checks it appears exactly 3 edges later
    task automatic send_one(input string tag, input logic [10:0] a, input logic [10:0] b,
                            input logic cin, input logic sub,
                            input logic [10:0] es, input logic ec, input logic eo);
        A = a; B = b; Cin = cin; op_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " lat1 valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, " lat2 valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, " lat3 valid"}, 64'(out_valid), 64'd1);
        check({tag, " sum"},  64'(Sum),  64'(es));
        check({tag, " cout"}, 64'(Cout), 64'(ec));
        check({tag, " ovf"},  64'(ovf),  64'(eo));
    endtask

    logic [10:0] sa [20];
    logic [10:0] sb [20];
    logic        sc [20];
    logic        ss [20];
    logic [12:0] se [20];

    initial begin
        int sent;
        int got;
        int cyc;
        int vcount;
        logic [12:0] held;

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1;
        held = '0;

        #3;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset sum",       64'(Sum),       64'd0);
        check("reset cout",      64'(Cout),      64'd0);
        check("reset ovf",       64'(ovf),       64'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_one("add wrap",   11'd2047, 11'd1,    1'b0, 1'b0, 11'd0,    1'b1, 1'b0);
        send_one("sub 5-7",    11'd5,    11'd7,    1'b0, 1'b1, 11'd2046, 1'b0, 1'b0);
        send_one("sub 7-5",    11'd7,    11'd5,    1'b0, 1'b1, 11'd2,    1'b1, 1'b0);
        send_one("ovf add",    11'd1023, 11'd1,    1'b0, 1'b0, 11'd1024, 1'b0, 1'b1);
        send_one("ovf sub",    11'd1024, 11'd1,    1'b0, 1'b1, 11'd1023, 1'b1, 1'b1);
        send_one("carry chain",11'h0FF,  11'h001,  1'b1, 1'b0, 11'h101,  1'b0, 1'b0);
        send_one("sub borrow", 11'd10,   11'd3,    1'b1, 1'b1, 11'd6,    1'b1, 1'b0);

        // Streaming with a 5-cycle consumer stall
        for (int i = 0; i < 20; i++) begin
            sa[i] = 11'($urandom_range(0, 2047));
            sb[i] = 11'($urandom_range(0, 2047));
            sc[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
            se[i] = model(sa[i], sb[i], sc[i], ss[i]);
        end
        sent = 0; got = 0; cyc = 0;
        @(negedge clk);
        while (got < 20 && cyc < 300) begin
            out_ready = !(cyc >= 8 && cyc < 13);
            if (sent < 20) begin
                in_valid = 1'b1; A = sa[sent]; B = sb[sent]; Cin = sc[sent]; op_sub = ss[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 8 && cyc < 13) begin
                check("stall in_ready",  64'(in_ready),  64'd0);
                check("stall out_valid", 64'(out_valid), 64'd1);
                if (cyc == 8) held = {ovf, Cout, Sum};
                else check("stall hold", 64'({ovf, Cout, Sum}), 64'(held));
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream result %0d", got), 64'({ovf, Cout, Sum}), 64'(se[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream count", 64'(got), 64'd20);

        // Reset with transactions in flight
        @(negedge clk);
        A = 11'd2047; B = 11'd2047; Cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        A = 11'd100; B = 11'd200;
        @(negedge clk);
        A = 11'd300; B = 11'd400;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-reset valid", 64'(out_valid), 64'd1);
        check("pre-reset sum",   64'(Sum),       64'd2047);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst sum",       64'(Sum),       64'd0);
        check("async rst cout",      64'(Cout),      64'd0);
        check("async rst in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("no stale output", 64'(vcount), 64'd0);

        // First edge after release must accept
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_one("after reset", 11'd300, 11'd400, 1'b0, 1'b0, 11'd700, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
